// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - instruction format codes and source-usage decode for the hazard scoreboard
package hazard_scoreboard_pkg;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5
  } insn_type_e;

  // Returns {uses_src2, uses_src1}; unknown formats read nothing.
  function automatic logic [1:0] src_usage(insn_type_e t);
    case (t)
      TYPE_R, TYPE_S, TYPE_B: src_usage = 2'b11;
      TYPE_I:                 src_usage = 2'b01;
      default:                src_usage = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage instruction handshake between decode and the hazard scoreboard
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 3
);
  logic              de_valid;
  logic [ADDR_W-1:0] de_src1;
  logic [ADDR_W-1:0] de_src2;
  logic [ADDR_W-1:0] de_rd;
  insn_type_e        de_type;
  logic              de_regwrt;
  logic [LAT_W-1:0]  de_lat;
  logic              de_long;
  logic              stall_processor;
  logic              issue;

  modport master (
    output de_valid, de_src1, de_src2, de_rd, de_type, de_regwrt, de_lat, de_long,
    input  stall_processor, issue
  );

  modport slave (
    input  de_valid, de_src1, de_src2, de_rd, de_type, de_regwrt, de_lat, de_long,
    output stall_processor, issue
  );
endinterface

// File: rtl/hazard_reg_timer.sv
// rtl/hazard_reg_timer.sv - pending-write countdown and long-op flag for one architectural register
module hazard_reg_timer
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_set_long,
  input  logic             i_clr_long,
  output logic [LAT_W-1:0] o_cnt,
  output logic             o_long,
  output logic             o_busy
);
  logic [LAT_W-1:0] r_cnt;
  logic             r_long;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  // A new long issue beats a completion to the same register in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_long <= 1'b0;
    end else if (i_set_long) begin
      r_long <= 1'b1;
    end else if (i_clr_long) begin
      r_long <= 1'b0;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_long = r_long;
  assign o_busy = r_long || (r_cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode hazard unit: RAW/WAW/long-unit stall detection over a per-register scoreboard
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int LAT_W     = 3,
  parameter int FWD_SLACK = 0,
  parameter int CNT_W     = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  hazard_scoreboard_if.slave  de,
  input  logic                i_pipe_hold,
  input  logic                i_long_done,
  input  logic [ADDR_W-1:0]   i_long_rd,
  output logic [NUM_REGS-1:0] o_busy_vec,
  output logic [CNT_W-1:0]    o_stall_cnt
);
  localparam logic [LAT_W-1:0] SLACK = LAT_W'(FWD_SLACK);

  logic [LAT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_long;
  logic [NUM_REGS-1:0] w_busy;
  logic [LAT_W-1:0]    w_eff_lat;
  logic [1:0]          w_use;
  logic                w_pend1;
  logic                w_pend2;
  logic                w_wr_any;
  logic                w_raw;
  logic                w_waw;
  logic                w_struct;
  logic                w_stall;
  logic                w_issue;
  logic [CNT_W-1:0]    r_stall_cnt;

  assign w_cnt[0]  = '0;
  assign w_long[0] = 1'b0;
  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_reg_timer #(.LAT_W(LAT_W)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_hold     (i_pipe_hold),
      .i_load     (w_issue && w_wr_any && !de.de_long && (de.de_rd == ADDR_W'(r))),
      .i_load_val (w_eff_lat),
      .i_set_long (w_issue && w_wr_any && de.de_long && (de.de_rd == ADDR_W'(r))),
      .i_clr_long (i_long_done && (i_long_rd == ADDR_W'(r))),
      .o_cnt      (w_cnt[r]),
      .o_long     (w_long[r]),
      .o_busy     (w_busy[r])
    );
  end

  // Hazards look only at registered scoreboard state, so a completing long op still stalls its reader this cycle.
  always_comb begin
    w_use     = src_usage(de.de_type);
    w_eff_lat = (de.de_lat == '0) ? LAT_W'(1) : de.de_lat;
    w_pend1   = (de.de_src1 != '0) && (w_long[de.de_src1] || (w_cnt[de.de_src1] > SLACK));
    w_pend2   = (de.de_src2 != '0) && (w_long[de.de_src2] || (w_cnt[de.de_src2] > SLACK));
    w_raw     = (w_use[0] && w_pend1) || (w_use[1] && w_pend2);
    w_wr_any  = de.de_regwrt && (de.de_rd != '0);
    if (de.de_long) begin
      w_waw = w_wr_any && (w_long[de.de_rd] || (w_cnt[de.de_rd] != '0));
    end else begin
      w_waw = w_wr_any && (w_long[de.de_rd] || (w_cnt[de.de_rd] > w_eff_lat));
    end
    w_struct = de.de_long && (|w_long);
    w_stall  = !i_rst && de.de_valid && (w_raw || w_waw || w_struct);
    w_issue  = !i_rst && de.de_valid && !w_stall && !i_pipe_hold;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign de.stall_processor = w_stall;
  assign de.issue           = w_issue;
  assign o_busy_vec         = i_rst ? '0 : w_busy;
  assign o_stall_cnt        = r_stall_cnt;
endmodule
